rs_frame_sequencer: RTL and testbench

- Frame-level controller for the RS(255,239) decoder.
- Accepts the incoming symbol stream and tells the syndrome stage when a frame is complete.
- Waits for Berlekamp-Massey to finish, then times the Chien search window (including its 13-deep error-flag shift register).
- Counts located error symbols, compares the count against the error-locator degree, and reports frame completion and decode failure to the correction/output stage.

---
 rtl/rs_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_rs_frame_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_frame_sequencer.sv
// RS(255,239) frame sequencer: symbol collection, BM wait, Chien window timing
// and per-frame error-count check against the error-locator degree.
module rs_frame_sequencer #(
    parameter int N          = 255,
    parameter int T          = 8,
    parameter int CHIEN_LAT  = 13,
    parameter int BM_TIMEOUT = 64
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       sym_valid,
    output logic       in_ready,
    output logic       Scalc_done,
    input  logic       BM_done,
    input  logic [3:0] lambda_deg,
    input  logic       Error_symbol,
    output logic       chien_active,
    output logic [7:0] chien_idx,
    output logic [3:0] err_count,
    output logic       frame_done,
    output logic       decode_fail,
    output logic       overrun
);

    localparam int WW = $clog2(BM_TIMEOUT);

    localparam logic [8:0]    LAST_SYM  = 9'(N - 1);
    localparam logic [8:0]    LAST_CYC  = 9'(N + CHIEN_LAT - 1);
    localparam logic [8:0]    LAT       = 9'(CHIEN_LAT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(BM_TIMEOUT - 1);
    localparam logic [3:0]    T_MAX     = 4'(T);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        BM_WAIT,
        CHIEN,
        REPORT
    } state_t;

    state_t        state;
    logic [8:0]    sym_cnt;
    logic [8:0]    cyc_cnt;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    deg_q;

    logic       in_window;
    logic [3:0] err_inc;
    logic [8:0] cyc_nxt;
    logic [8:0] idx_nxt;
    logic       fail_chk;

    // err_inc already includes this cycle's flag so the final sample
    // at the last window cycle is part of the reported count.
    always_comb begin
        in_window = (cyc_cnt >= LAT);
        err_inc   = err_count;
        if (in_window && Error_symbol && (err_count != 4'hF))
            err_inc = err_count + 4'd1;
        cyc_nxt  = cyc_cnt + 9'd1;
        idx_nxt  = cyc_nxt - LAT;
        fail_chk = (deg_q > T_MAX) || (err_inc != deg_q);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sym_cnt      <= '0;
            cyc_cnt      <= '0;
            wait_cnt     <= '0;
            deg_q        <= '0;
            in_ready     <= 1'b1;
            Scalc_done   <= 1'b0;
            chien_active <= 1'b0;
            chien_idx    <= '0;
            err_count    <= '0;
            frame_done   <= 1'b0;
            decode_fail  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            Scalc_done <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sym_valid) begin
                        if (frame_start) begin
                            sym_cnt <= 9'd1;
                            state   <= COLLECT;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (sym_valid) begin
                        if (frame_start) begin
                            sym_cnt <= 9'd1;
                            overrun <= 1'b1;
                        end else if (sym_cnt == LAST_SYM) begin
                            sym_cnt    <= '0;
                            wait_cnt   <= '0;
                            Scalc_done <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= BM_WAIT;
                        end else begin
                            sym_cnt <= sym_cnt + 9'd1;
                        end
                    end
                end
                BM_WAIT: begin
                    overrun <= sym_valid;
                    // BM_done takes priority over an expiring timeout
                    if (BM_done) begin
                        deg_q        <= lambda_deg;
                        cyc_cnt      <= '0;
                        err_count    <= '0;
                        chien_idx    <= '0;
                        chien_active <= 1'b1;
                        state        <= CHIEN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        decode_fail <= 1'b1;
                        frame_done  <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                CHIEN: begin
                    overrun   <= sym_valid;
                    err_count <= err_inc;
                    if (cyc_cnt == LAST_CYC) begin
                        chien_active <= 1'b0;
                        chien_idx    <= '0;
                        frame_done   <= 1'b1;
                        decode_fail  <= fail_chk;
                        state        <= REPORT;
                    end else begin
                        cyc_cnt <= cyc_nxt;
                        if (cyc_nxt >= LAT)
                            chien_idx <= idx_nxt[7:0];
                        else
                            chien_idx <= '0;
                    end
                end
                REPORT: begin
                    overrun  <= sym_valid;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_frame_sequencer.sv
// Randomized self-checking bench for rs_frame_sequencer with a
// frame-level reference model (flag counting and cycle arithmetic).
module tb_rs_frame_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       sym_valid = 1'b0;
    logic       BM_done = 1'b0;
    logic [3:0] lambda_deg = 4'h0;
    logic       Error_symbol = 1'b0;
    logic       in_ready, Scalc_done, chien_active;
    logic       frame_done, decode_fail, overrun;
    logic [7:0] chien_idx;
    logic [3:0] err_count;
    logic [17:0] out_vec;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [3:0] model_err = 4'h0;
    logic       model_fail = 1'b0;
    bit flag_at [0:268];

    localparam logic [17:0] RST_VEC = 18'h20000;

    rs_frame_sequencer dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .frame_start(frame_start), .sym_valid(sym_valid),
        .in_ready(in_ready), .Scalc_done(Scalc_done),
        .BM_done(BM_done), .lambda_deg(lambda_deg),
        .Error_symbol(Error_symbol), .chien_active(chien_active),
        .chien_idx(chien_idx), .err_count(err_count),
        .frame_done(frame_done), .decode_fail(decode_fail),
        .overrun(overrun)
    );

    assign out_vec = {in_ready, Scalc_done, chien_active, chien_idx,
                      err_count, frame_done, decode_fail, overrun};

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_flags();
        for (int c = 0; c <= 268; c++) flag_at[c] = 1'b0;
    endtask

    task automatic set_random_flags(input int k, input int lo, input int hi);
        for (int i = 0; i < k; i++) flag_at[$urandom_range(hi, lo)] = 1'b1;
    endtask

    task automatic send_syms(input int abort_at, input bit gaps);
        int bad = 0;
        for (int s = 0; s < abort_at + 255; s++) begin
            if (gaps) begin
                while ($urandom_range(3, 0) == 0) begin
                    sym_valid = 1'b0;
                    frame_start = 1'($urandom);
                    step();
                    if (Scalc_done !== 1'b0 || in_ready !== 1'b1) bad++;
                end
            end
            if (in_ready !== 1'b1) bad++;
            sym_valid = 1'b1;
            frame_start = (s == 0) || (s == abort_at);
            step();
            if (abort_at > 0 && s == abort_at) begin
                n_checks++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_overrun: got %b expected 1", overrun);
                end
            end else if (overrun !== 1'b0) begin
                bad++;
            end
            if (s != abort_at + 254 && Scalc_done !== 1'b0) bad++;
        end
        sym_valid = 1'b0;
        frame_start = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL collect_trace: got %0d bad cycles expected 0", bad);
        end
        n_checks++;
        if ({Scalc_done, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL scalc_done: got %b expected 10",
                     {Scalc_done, in_ready});
        end
    endtask

    task automatic chien_run(input int d, input logic [3:0] deg,
                             input int spur_c, input bit rep_poke,
                             input string name);
        int bad = 0;
        int cnt = 0;
        int bm_c = $urandom_range(267, 0);
        logic [3:0] exp_err;
        logic exp_fail;
        logic [7:0] exp_idx;
        for (int c = 13; c <= 267; c++) cnt += int'(flag_at[c]);
        exp_err = (cnt > 15) ? 4'hF : 4'(cnt);
        exp_fail = (deg > 4'd8) || (exp_err != deg);
        for (int i = 0; i < d; i++) begin
            Error_symbol = 1'($urandom);
            step();
            if (frame_done !== 1'b0 || chien_active !== 1'b0) bad++;
        end
        BM_done = 1'b1;
        lambda_deg = deg;
        step();
        BM_done = 1'b0;
        for (int c = 0; c <= 267; c++) begin
            exp_idx = (c >= 13) ? 8'(c - 13) : 8'd0;
            if (chien_active !== 1'b1 || chien_idx !== exp_idx) bad++;
            if (frame_done !== 1'b0) bad++;
            if (overrun !== 1'((spur_c >= 0) && (c == spur_c + 1))) bad++;
            Error_symbol = flag_at[c];
            sym_valid = (c == spur_c);
            frame_start = sym_valid & 1'($urandom);
            BM_done = (c == bm_c);
            lambda_deg = 4'($urandom);
            step();
        end
        BM_done = 1'b0;
        Error_symbol = flag_at[268];
        sym_valid = rep_poke;
        frame_start = rep_poke;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s chien_trace: got %0d bad cycles expected 0",
                     name, bad);
        end
        n_checks++;
        if (overrun !== 1'(spur_c == 267)) begin
            n_fail++;
            $display("FAIL %s report_overrun: got %b", name, overrun);
        end
        n_checks++;
        if ({frame_done, chien_active, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s frame_done_latency: got %b expected 100",
                     name, {frame_done, chien_active, in_ready});
        end
        n_checks++;
        if (err_count !== exp_err) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d expected %0d",
                     name, err_count, exp_err);
        end
        n_checks++;
        if (decode_fail !== exp_fail) begin
            n_fail++;
            $display("FAIL %s decode_fail: got %b expected %b",
                     name, decode_fail, exp_fail);
        end
        step();
        sym_valid = 1'b0;
        frame_start = 1'b0;
        Error_symbol = 1'b0;
        n_checks++;
        if ({frame_done, in_ready, overrun, err_count, decode_fail} !==
            {2'b01, rep_poke, exp_err, exp_fail}) begin
            n_fail++;
            $display("FAIL %s post_report: got %b expected %b", name,
                     {frame_done, in_ready, overrun, err_count, decode_fail},
                     {2'b01, rep_poke, exp_err, exp_fail});
        end
        model_err = exp_err;
        model_fail = exp_fail;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", out_vec, RST_VEC);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", out_vec, RST_VEC);
        end
    endtask

    task automatic test_clean();
        clear_flags();
        send_syms(0, 1'b0);
        chien_run(5, 4'd0, -1, 1'b0, "clean");
    endtask

    task automatic test_correctable();
        clear_flags();
        flag_at[10 + 13] = 1'b1;
        flag_at[100 + 13] = 1'b1;
        flag_at[254 + 13] = 1'b1;
        send_syms(0, 1'b1);
        chien_run($urandom_range(20, 0), 4'd3, -1, 1'b0, "correctable");
    endtask

    task automatic test_mismatch();
        clear_flags();
        flag_at[40] = 1'b1;
        flag_at[200] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(2, 4'd3, -1, 1'b0, "count_mismatch");
        clear_flags();
        for (int i = 0; i < 9; i++) flag_at[20 + 25 * i] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(0, 4'd9, -1, 1'b0, "over_degree");
    endtask

    task automatic test_window_edges();
        clear_flags();
        flag_at[12] = 1'b1;
        flag_at[13] = 1'b1;
        flag_at[267] = 1'b1;
        flag_at[268] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(7, 4'd2, -1, 1'b0, "window_edges");
    endtask

    task automatic test_saturation();
        clear_flags();
        for (int i = 0; i < 20; i++) flag_at[15 + 12 * i] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(1, 4'd15, -1, 1'b0, "saturation");
    endtask

    task automatic test_timeout();
        int bad = 0;
        send_syms(0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            Error_symbol = 1'($urandom);
            step();
            if (chien_active !== 1'b0) bad++;
            if (i < 64 && frame_done !== 1'b0) bad++;
        end
        Error_symbol = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_trace: got %0d bad cycles expected 0", bad);
        end
        n_checks++;
        if ({frame_done, decode_fail, err_count} !== {2'b11, model_err}) begin
            n_fail++;
            $display("FAIL timeout_report: got %b expected %b",
                     {frame_done, decode_fail, err_count}, {2'b11, model_err});
        end
        step();
        n_checks++;
        if ({frame_done, in_ready, decode_fail} !== 3'b011) begin
            n_fail++;
            $display("FAIL timeout_post: got %b expected 011",
                     {frame_done, in_ready, decode_fail});
        end
        model_fail = 1'b1;
    endtask

    task automatic test_bm_at_limit();
        clear_flags();
        flag_at[150] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(63, 4'd1, -1, 1'b0, "bm_at_limit");
    endtask

    task automatic test_abort();
        clear_flags();
        set_random_flags(4, 13, 267);
        send_syms(100, 1'b1);
        chien_run(4, 4'd4, -1, 1'b0, "abort");
    endtask

    task automatic test_spurious();
        sym_valid = 1'b1;
        frame_start = 1'b0;
        step();
        sym_valid = 1'b0;
        n_checks++;
        if ({overrun, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_overrun: got %b expected 11",
                     {overrun, in_ready});
        end
        step();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_overrun_pulse: got %b expected 0", overrun);
        end
        clear_flags();
        set_random_flags(5, 13, 267);
        send_syms(0, 1'b0);
        chien_run(3, 4'd5, $urandom_range(266, 0), 1'b0, "chien_overrun");
    endtask

    task automatic test_random();
        logic [3:0] deg;
        for (int f = 0; f < 5; f++) begin
            deg = 4'($urandom_range(10, 0));
            clear_flags();
            if ($urandom_range(1, 0) == 1)
                set_random_flags(int'(deg), 13, 267);
            else
                set_random_flags($urandom_range(12, 0), 0, 268);
            send_syms(0, 1'b1);
            chien_run($urandom_range(63, 0), deg,
                      ($urandom_range(1, 0) == 1) ? $urandom_range(267, 0) : -1,
                      1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        clear_flags();
        set_random_flags(2, 13, 267);
        send_syms(0, 1'b0);
        chien_run(0, 4'd2, -1, 1'b1, "b2b_first");
        clear_flags();
        send_syms(0, 1'b0);
        chien_run(0, 4'd0, -1, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        clear_flags();
        send_syms(0, 1'b0);
        BM_done = 1'b1;
        lambda_deg = 4'd1;
        step();
        BM_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            Error_symbol = 1'($urandom);
            step();
        end
        Error_symbol = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_chien: got %h expected %h",
                     out_vec, RST_VEC);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (out_vec !== RST_VEC) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d bad cycles expected 0", bad);
        end
        model_err = 4'h0;
        model_fail = 1'b0;
        clear_flags();
        flag_at[30] = 1'b1;
        send_syms(0, 1'b0);
        chien_run(5, 4'd1, -1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correctable();
        test_mismatch();
        test_window_edges();
        test_saturation();
        test_timeout();
        test_bm_at_limit();
        test_abort();
        test_spurious();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
